fifo_rd_packer: RTL and testbench



---
 rtl/shared_pkg.sv | 28 ++
 rtl/fifo_rd_packer_out_reg.sv | 57 +++++
 rtl/fifo_rd_packer.sv | 147 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// -----------------------------------------------------------------------------
// shared_pkg
// Shared definitions for the FIFO read-side packer.
//   FIFO_WIDTH     : default width of one FIFO word
//   PACK           : default number of words per output beat (2..4)
//   packer_state_e : assembly-side FSM states
//   beat_t         : one output beat (keep mask + packed data) at the defaults
// -----------------------------------------------------------------------------
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int PACK       = 2;

    // COLLECT : gathering words, no beat ready for hand-off
    // HOLD    : a complete beat sits in the assembly register
    // FLUSH   : a partial beat has been requested and is waiting to leave
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        FLUSH   = 2'd2
    } packer_state_e;

    typedef struct packed {
        logic [PACK-1:0]            keep;
        logic [FIFO_WIDTH*PACK-1:0] data;
    } beat_t;

endpackage

// File: rtl/fifo_rd_packer_out_reg.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_out_reg
// One-entry valid/ready holding register for the packed output beat.
//   clk, rst : clock and synchronous active-high reset
//   i_load   : load i_data/i_keep this cycle (only when o_free is high)
//   i_data   : beat data to load
//   i_keep   : word keep mask to load
//   i_ready  : downstream ready
//   o_valid  : beat valid
//   o_data   : held beat data
//   o_keep   : held keep mask
//   o_free   : register can accept a load this cycle
// -----------------------------------------------------------------------------
module fifo_rd_packer_out_reg #(
    parameter int W = 32,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic [K-1:0] i_keep,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [K-1:0] o_keep,
    output logic         o_free
);
    import shared_pkg::*;

    logic         r_valid;
    logic [W-1:0] r_data;
    logic [K-1:0] r_keep;

    // Free when empty or when the current beat is handed off this cycle,
    // so back-to-back beats need no bubble.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
        end else if (r_valid && i_ready) begin
            // Data is left in place; only valid drops.
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Pops FIFO_WIDTH-bit words from a synchronous FIFO (1-cycle read latency) and
// packs PACK consecutive words into one beat on a valid/ready master port.
// A flush pulse pushes out a partially filled beat.
//   clk, rst      : clock and synchronous active-high reset
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : FIFO read request
//   fifo_data_out : FIFO read data, valid the cycle after an accepted read
//   flush         : single-cycle request to emit the current partial beat
//   m_valid       : output beat valid
//   m_ready       : downstream ready
//   m_data        : packed beat, word 0 (first popped) in the low bits
//   m_keep        : bit i set when word i of m_data is valid
//   words_held    : words currently in the assembly register
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int PACK       = shared_pkg::PACK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0]      fifo_data_out,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic [2:0]                 words_held
);
    import shared_pkg::*;

    localparam logic [2:0] PACK_W = 3'(PACK);

    logic [2:0]                 r_words_held;
    logic [2:0]                 w_words_next;
    logic                       r_inflight;
    logic                       r_flush_pend;
    logic                       w_flush_pend_next;
    packer_state_e              r_state;
    packer_state_e              w_state_next;
    logic [FIFO_WIDTH-1:0]      r_asm [PACK];

    logic [3:0]                 w_occupancy;
    logic                       w_out_free;
    logic                       w_beat_full;
    logic                       w_beat_flush;
    logic                       w_transfer;
    logic [FIFO_WIDTH*PACK-1:0] w_beat_data;
    logic [PACK-1:0]            w_beat_keep;

    // Counting the outstanding read as occupied keeps a single read in flight
    // and guarantees the assembly register never overflows.
    assign w_occupancy = {1'b0, r_words_held} + {3'b000, r_inflight};
    assign fifo_rd_en  = !rst && !fifo_empty && !r_flush_pend
                         && (w_occupancy < 4'(PACK));

    // r_state is computed one cycle ahead from the next-state values, so it
    // describes what the assembly register offers in the current cycle.
    assign w_beat_full  = (r_state == HOLD);
    assign w_beat_flush = (r_state == FLUSH) && !r_inflight;
    assign w_transfer   = w_out_free && (w_beat_full || w_beat_flush);

    always_comb begin
        w_words_next = r_words_held;
        // Capture and transfer never coincide: a full beat blocks reads, and a
        // flush transfer waits for the in-flight word.
        if (w_transfer) begin
            w_words_next = 3'd0;
        end else if (r_inflight) begin
            w_words_next = r_words_held + 3'd1;
        end

        // A flush only sticks if data is (or is about to be) held; a flush
        // with nothing to emit is dropped, and any transfer satisfies it.
        w_flush_pend_next = (r_flush_pend || flush) && !w_transfer
                            && ((w_words_next != 3'd0) || fifo_rd_en);

        w_state_next = COLLECT;
        if (w_words_next == PACK_W) begin
            w_state_next = HOLD;
        end else if (w_flush_pend_next && (w_words_next != 3'd0)) begin
            w_state_next = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_words_held <= 3'd0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_state      <= COLLECT;
        end else begin
            r_words_held <= w_words_next;
            r_inflight   <= fifo_rd_en;
            r_flush_pend <= w_flush_pend_next;
            r_state      <= w_state_next;
        end
    end

    // The returning word lands in the next free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PACK; i++) begin
                r_asm[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PACK; i++) begin
                if (r_inflight && (r_words_held == 3'(i))) begin
                    r_asm[i] <= fifo_data_out;
                end
            end
        end
    end

    // Slots beyond words_held may hold stale words from an earlier beat, so
    // they are forced to zero in the outgoing beat.
    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_slot
            assign w_beat_keep[gi] = (r_words_held > 3'(gi));
            assign w_beat_data[gi*FIFO_WIDTH +: FIFO_WIDTH] =
                (r_words_held > 3'(gi)) ? r_asm[gi] : '0;
        end
    endgenerate

    fifo_rd_packer_out_reg #(
        .W (FIFO_WIDTH*PACK),
        .K (PACK)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_transfer),
        .i_data  (w_beat_data),
        .i_keep  (w_beat_keep),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_keep  (m_keep),
        .o_free  (w_out_free)
    );

    assign words_held = r_words_held;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Self-checking bench for fifo_rd_packer at the default FIFO_WIDTH=16, PACK=2.
// A queue-based FIFO model feeds the DUT; a monitor records every handshake.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;
    import shared_pkg::*;

    localparam int W  = FIFO_WIDTH;
    localparam int DW = FIFO_WIDTH*PACK;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_data_out = '0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [PACK-1:0] m_keep;
    logic [2:0]    words_held;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] push_req[$];
    logic [W-1:0] ref_q[$];
    beat_t        obs_q[$];
    logic         prev_stall = 1'b0;
    beat_t        prev_beat = '0;

    typedef struct {
        logic [63:0]     words;
        int              n;
        bit              do_flush;
        logic [DW-1:0]   exp_data;
        logic [PACK-1:0] exp_keep;
    } vec_t;

    fifo_rd_packer dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_keep        (m_keep),
        .words_held    (words_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FIFO model: 1-cycle read latency; pushes become visible at the next edge.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty && fifo_q.size() > 0) begin
            fifo_data_out <= fifo_q.pop_front();
        end
        while (push_req.size() > 0) begin
            fifo_q.push_back(push_req.pop_front());
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Handshake monitor and hold-stable check while stalled.
    always @(posedge clk) begin
        if (!rst && prev_stall) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", 64'(m_data), 64'(prev_beat.data));
            chk("stall_keep", 64'(m_keep), 64'(prev_beat.keep));
        end
        if (!rst && m_valid && m_ready) begin
            obs_q.push_back(beat_t'{keep: m_keep, data: m_data});
        end
        prev_stall = !rst && m_valid && !m_ready;
        prev_beat  = beat_t'{keep: m_keep, data: m_data};
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] w);
        push_req.push_back(w);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_held(input string name, input logic [2:0] n);
        int cnt = 0;
        while (words_held != n && cnt < 100) begin
            tick(1);
            cnt++;
        end
        if (words_held != n) begin
            total++;
            bad++;
            $display("FAIL %s: words_held got %0d expected %0d within 100 cycles", name, words_held, n);
        end
    endtask

    task automatic get_beat(input string name, output beat_t b);
        int cnt = 0;
        b = '0;
        while (obs_q.size() == 0 && cnt < 100) begin
            tick(1);
            cnt++;
        end
        if (obs_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no beat, expected a beat within 100 cycles", name);
        end else begin
            b = obs_q.pop_front();
        end
    endtask

    task automatic chk_beat(input string name, input logic [DW-1:0] d, input logic [PACK-1:0] k);
        beat_t b;
        get_beat(name, b);
        chk({name, "_data"}, 64'(b.data), 64'(d));
        chk({name, "_keep"}, 64'(b.keep), 64'(k));
        $display("beat %s: data=%h keep=%b", name, b.data, b.keep);
    endtask

    initial begin
        vec_t        vecs[6];
        beat_t       b;
        int          flush_cnt;
        int          partials;
        int          k;
        logic [W-1:0] w;
        logic [PACK-1:0] mask;

        vecs[0] = '{64'h0000_0000_5555_AAAA, 2, 1'b0, 32'h5555_AAAA, 2'b11};
        vecs[1] = '{64'h0000_0000_0000_1234, 1, 1'b1, 32'h0000_1234, 2'b01};
        vecs[2] = '{64'h0000_0000_0002_0001, 2, 1'b0, 32'h0002_0001, 2'b11};
        vecs[3] = '{64'h0000_0000_0000_BEEF, 1, 1'b1, 32'h0000_BEEF, 2'b01};
        vecs[4] = '{64'h0000_0000_0000_FFFF, 2, 1'b0, 32'h0000_FFFF, 2'b11};
        vecs[5] = '{64'h0000_0000_7FFE_8001, 2, 1'b0, 32'h7FFE_8001, 2'b11};

        // Reset with a non-empty FIFO.
        rst = 1'b1;
        push(16'hAAAA);
        push(16'h5555);
        tick(2);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_keep", 64'(m_keep), 64'd0);
        chk("rst_held", 64'(words_held), 64'd0);
        $display("reset: rd_en=%b valid=%b held=%0d", fifo_rd_en, m_valid, words_held);

        // Full pack of the words queued during reset.
        rst = 1'b0;
        m_ready = 1'b1;
        chk_beat("full", 32'h5555_AAAA, 2'b11);
        tick(10);
        chk("full_idle_rd", 64'(fifo_rd_en), 64'd0);
        chk("full_no_extra", 64'(obs_q.size()), 64'd0);

        // Table of single-beat vectors.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                w = vecs[i].words[j*16 +: 16];
                push(w);
            end
            if (vecs[i].do_flush) begin
                wait_held($sformatf("vec%0d_held", i), 3'(vecs[i].n));
                pulse_flush();
            end
            chk_beat($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_keep);
        end
        tick(5);
        chk("vec_no_extra", 64'(obs_q.size()), 64'd0);

        // Backpressure: six words with the sink stalled.
        m_ready = 1'b0;
        for (int v = 1; v <= 6; v++) push(16'(v));
        tick(20);
        chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("bp_held", 64'(words_held), 64'd2);
        chk("bp_valid", 64'(m_valid), 64'd1);
        chk("bp_data", 64'(m_data), 64'h0002_0001);
        m_ready = 1'b1;
        chk_beat("bp0", 32'h0002_0001, 2'b11);
        chk_beat("bp1", 32'h0004_0003, 2'b11);
        chk_beat("bp2", 32'h0006_0005, 2'b11);

        // Flush in the same cycle the first read is issued.
        tick(5);
        push(16'h00C3);
        tick(1);
        chk("fdr_rd_en", 64'(fifo_rd_en), 64'd1);
        pulse_flush();
        chk_beat("fdr", 32'h0000_00C3, 2'b01);
        tick(10);
        chk("fdr_single", 64'(obs_q.size()), 64'd0);

        // Spurious flush while idle.
        pulse_flush();
        tick(10);
        chk("spur_no_beat", 64'(obs_q.size()), 64'd0);
        chk("spur_valid", 64'(m_valid), 64'd0);

        // Reset with one word held.
        push(16'h0BAD);
        wait_held("mrst_held1", 3'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_held", 64'(words_held), 64'd0);
        chk("mrst_valid", 64'(m_valid), 64'd0);
        push(16'h0011);
        push(16'h0022);
        chk_beat("mrst", 32'h0022_0011, 2'b11);
        tick(5);
        chk("mrst_no_extra", 64'(obs_q.size()), 64'd0);

        // Randomized traffic against an order-preserving reference.
        obs_q.delete();
        flush_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && (fifo_q.size() + push_req.size()) < 8) begin
                w = 16'($urandom);
                push(w);
                ref_q.push_back(w);
            end
            flush = ($urandom_range(0, 15) == 0);
            if (flush) flush_cnt++;
            tick(1);
        end
        flush = 1'b0;
        m_ready = 1'b1;
        tick(20);
        pulse_flush();
        flush_cnt++;
        tick(20);
        chk("rand_drained_held", 64'(words_held), 64'd0);
        chk("rand_drained_valid", 64'(m_valid), 64'd0);

        partials = 0;
        while (obs_q.size() > 0) begin
            b = obs_q.pop_front();
            k = 0;
            for (int i = 0; i < PACK; i++) if (b.keep[i]) k++;
            mask = '0;
            for (int i = 0; i < k; i++) mask[i] = 1'b1;
            chk("rand_nonempty", 64'(k > 0), 64'd1);
            chk("rand_keep", 64'(b.keep), 64'(mask));
            if (k < PACK) partials++;
            for (int i = 0; i < PACK; i++) begin
                if (i < k) begin
                    if (ref_q.size() == 0) begin
                        chk("rand_extra_word", 64'(b.data[i*W +: W]), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("rand_word", 64'(b.data[i*W +: W]), 64'(ref_q.pop_front()));
                    end
                end else begin
                    chk("rand_pad", 64'(b.data[i*W +: W]), 64'd0);
                end
            end
            $display("rand beat: data=%h keep=%b", b.data, b.keep);
        end
        chk("rand_lost_words", 64'(ref_q.size()), 64'd0);
        chk("rand_partials_vs_flush", 64'(partials <= flush_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
